// File: rtl/exc_pkg.sv
// Shared exception codes and arbiter FSM state type for the csr / exc_arbiter slice.
package exc_pkg;

  localparam int EX_CODE_W = 6;
  localparam int THR_ID_W  = 8;

  // Exception codes reported by each thread csr.
  localparam logic [EX_CODE_W-1:0] EX_CLR   = 6'h00;
  localparam logic [EX_CODE_W-1:0] ALU_EX   = 6'h01;
  localparam logic [EX_CODE_W-1:0] IL_OP    = 6'h05;
  localparam logic [EX_CODE_W-1:0] STACK_OV = 6'h0B;
  localparam logic [EX_CODE_W-1:0] SEGFAULT = 6'h12;
  localparam logic [EX_CODE_W-1:0] BRKPT    = 6'h3F;

  // Arbiter states: one report is in flight from REPORT until DRAIN completes.
  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_REPORT      = 3'd1,
    ST_WAIT_RESUME = 3'd2,
    ST_CLEAR       = 3'd3,
    ST_DRAIN       = 3'd4
  } exc_state_e;

  // Everything except a breakpoint is treated as fatal by the host.
  function automatic logic is_fatal(input logic [EX_CODE_W-1:0] code);
    return (code != BRKPT);
  endfunction

endpackage

// File: rtl/exc_arbiter_rr_pick.sv
// Combinational round-robin picker: first request at or after ptr, wrapping.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  localparam int SW = IDX_W + 1;

  logic [N-1:0]  rot;
  logic [SW-1:0] sum;

  // Rotate requests so ptr sits at bit 0, take the lowest set bit, map back.
  always_comb begin
    rot   = N'({req, req} >> ptr);
    any   = |req;
    sum   = '0;
    grant = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = SW'(ptr) + SW'(k);
      end
    end
    if (sum >= SW'(N)) begin
      sum = sum - SW'(N);
    end
    idx = sum[IDX_W-1:0];
    for (int i = 0; i < N; i++) begin
      if (any && (sum == SW'(i))) begin
        grant[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/exc_arbiter.sv
// Exception arbiter: serves per-thread csr stalls one at a time in round-robin
// order, reports each to the host, and clears the csr after the host resumes.
//
// Host handshake (exc_valid / exc_ready): a report transfers on any posedge
// where both are high. While exc_valid is high and exc_ready low, exc_thr_id,
// exc_code and exc_fatal hold constant; exc_valid only drops after a transfer
// or on reset.
module exc_arbiter
  import exc_pkg::*;
#(
  parameter int NUM_THR = 4,
  parameter int CNT_W   = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_THR-1:0]               csr_stall,
  input  logic [NUM_THR-1:0][EX_CODE_W-1:0] ex_code,
  input  logic [NUM_THR-1:0][THR_ID_W-1:0]  thr_id,
  output logic [NUM_THR-1:0]               clr_ex,
  output logic                             exc_valid,
  input  logic                             exc_ready,
  output logic [THR_ID_W-1:0]              exc_thr_id,
  output logic [EX_CODE_W-1:0]             exc_code,
  output logic                             exc_fatal,
  input  logic                             host_resume,
  output logic [CNT_W-1:0]                 exc_count,
  output logic                             busy,
  output exc_state_e                       dbg_state,
  output logic [$clog2(NUM_THR)-1:0]       dbg_rr_ptr
);

  localparam int IDX_W = $clog2(NUM_THR);

  exc_state_e           state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]     sel_idx_q, sel_idx_d;
  logic [NUM_THR-1:0]   sel_oh_q, sel_oh_d;
  logic [THR_ID_W-1:0]  lat_id_q, lat_id_d;
  logic [EX_CODE_W-1:0] lat_code_q, lat_code_d;
  logic [CNT_W-1:0]     exc_count_q, exc_count_d;

  logic [NUM_THR-1:0]   pick_grant;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;

  rr_pick #(
    .N     (NUM_THR),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req   (csr_stall),
    .ptr   (rr_ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // State and latched-report registers; reset aborts any report in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      sel_idx_q   <= '0;
      sel_oh_q    <= '0;
      lat_id_q    <= '0;
      lat_code_q  <= '0;
      exc_count_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      sel_idx_q   <= sel_idx_d;
      sel_oh_q    <= sel_oh_d;
      lat_id_q    <= lat_id_d;
      lat_code_q  <= lat_code_d;
      exc_count_q <= exc_count_d;
    end
  end

  // Next-state logic: pick and latch in IDLE, then walk one report to completion.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    sel_idx_d   = sel_idx_q;
    sel_oh_d    = sel_oh_q;
    lat_id_d    = lat_id_q;
    lat_code_d  = lat_code_q;
    exc_count_d = exc_count_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          sel_idx_d  = pick_idx;
          sel_oh_d   = pick_grant;
          lat_id_d   = thr_id[pick_idx];
          lat_code_d = ex_code[pick_idx];
          state_d    = ST_REPORT;
        end
      end
      ST_REPORT: begin
        if (exc_ready) begin
          if (exc_count_q != {CNT_W{1'b1}}) begin
            exc_count_d = exc_count_q + CNT_W'(1);
          end
          state_d = ST_WAIT_RESUME;
        end
      end
      ST_WAIT_RESUME: begin
        if (host_resume) begin
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Wait for the csr to drop its flag so the same stall is not re-picked.
        if ((csr_stall & sel_oh_q) == '0) begin
          rr_ptr_d = (sel_idx_q == IDX_W'(NUM_THR - 1)) ? '0 : sel_idx_q + IDX_W'(1);
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from state; report fields read as zero while idle.
  always_comb begin
    busy       = (state_q != ST_IDLE);
    exc_valid  = (state_q == ST_REPORT);
    clr_ex     = (state_q == ST_CLEAR) ? sel_oh_q : '0;
    exc_thr_id = busy ? lat_id_q : '0;
    exc_code   = busy ? lat_code_q : '0;
    exc_fatal  = busy & is_fatal(lat_code_q);
    exc_count  = exc_count_q;
    dbg_state  = state_q;
    dbg_rr_ptr = rr_ptr_q;
  end

endmodule

// File: tb/tb_exc_arbiter.sv
// Bench for exc_arbiter: csr and host behaviour driven from one process,
// reports checked against an expected queue by a negedge monitor.
module tb_exc_arbiter;
  import exc_pkg::*;

  localparam int N     = 4;
  localparam int CW    = 3;
  localparam int REP_W = 19;
  localparam int MAXW  = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]      csr_stall;
  logic [N-1:0][5:0] ex_code;
  logic [N-1:0][7:0] thr_id;
  logic              exc_ready;
  logic              host_resume;
  logic [N-1:0]      clr_ex;
  logic              exc_valid;
  logic [7:0]        exc_thr_id;
  logic [5:0]        exc_code;
  logic              exc_fatal;
  logic [CW-1:0]     exc_count;
  logic              busy;
  exc_state_e        dbg_state;
  logic [1:0]        dbg_rr_ptr;

  exc_arbiter #(.NUM_THR(N), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .csr_stall   (csr_stall),
    .ex_code     (ex_code),
    .thr_id      (thr_id),
    .clr_ex      (clr_ex),
    .exc_valid   (exc_valid),
    .exc_ready   (exc_ready),
    .exc_thr_id  (exc_thr_id),
    .exc_code    (exc_code),
    .exc_fatal   (exc_fatal),
    .host_resume (host_resume),
    .exc_count   (exc_count),
    .busy        (busy),
    .dbg_state   (dbg_state),
    .dbg_rr_ptr  (dbg_rr_ptr)
  );

  int checks = 0;
  int errors = 0;
  int model_ptr = 0;
  int drop_cd[N];

  // Report item: {idx[3:0], id[7:0], code[5:0], fatal}
  logic [REP_W-1:0] exp_q[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  function automatic logic [REP_W-1:0] pack_rep(int idx, logic [7:0] id, logic [5:0] code);
    return {4'(idx), id, code, (code != 6'h3F)};
  endfunction

  function automatic logic [5:0] rand_code();
    logic [5:0] codes [5];
    codes = '{6'h01, 6'h05, 6'h0B, 6'h12, 6'h3F};
    return codes[$urandom_range(0, 4)];
  endfunction

  // Reference rule: lowest pending index at or after ptr, wrapping.
  function automatic int pick(logic [N-1:0] pend, int ptr);
    for (int k = 0; k < N; k++) begin
      if (pend[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  // ---------------- scoreboard monitor ----------------
  logic [REP_W-1:0] cur;
  bit in_report   = 1'b0;
  bit wait_resume = 1'b0;
  bit resume_seen = 1'b0;
  int acc_idx     = 0;
  int model_cnt   = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_report   = 1'b0;
      wait_resume = 1'b0;
      resume_seen = 1'b0;
      model_cnt   = 0;
    end else begin
      chk("exc_count", 32'(exc_count), model_cnt);
      if (clr_ex != '0) begin
        chk("clr_authorised", 32'(resume_seen), 1);
        chk("clr_onehot", 32'(clr_ex), 32'(1) << acc_idx);
        resume_seen = 1'b0;
      end
      if (host_resume && wait_resume) begin
        resume_seen = 1'b1;
        wait_resume = 1'b0;
      end
      if (exc_valid) begin
        if (!in_report) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_report", 1, 0);
            cur = {4'(0), exc_thr_id, exc_code, exc_fatal};
          end else begin
            cur = exp_q.pop_front();
          end
          in_report = 1'b1;
        end
        chk("exc_thr_id", 32'(exc_thr_id), 32'(cur[14:7]));
        chk("exc_code", 32'(exc_code), 32'(cur[6:1]));
        chk("exc_fatal", 32'(exc_fatal), 32'(cur[0]));
        if (exc_ready) begin
          if (model_cnt != (1 << CW) - 1) model_cnt++;
          in_report   = 1'b0;
          acc_idx     = int'(cur[18:15]);
          wait_resume = 1'b1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One cycle: step past the posedge, then let each csr react to clr_ex.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (drop_cd[i] > 0) begin
        drop_cd[i]--;
        if (drop_cd[i] == 0) csr_stall[i] = 1'b0;
      end
      if (clr_ex[i]) drop_cd[i] = $urandom_range(1, 3);
    end
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!exc_valid && t < MAXW) begin
      step();
      t++;
    end
    chk("valid_timeout", 32'(exc_valid), 1);
  endtask

  task automatic serve_one(int idx, int hold, bit early, bit scribble,
                           int late, logic [7:0] lid, logic [5:0] lcode);
    wait_valid();
    if (!exc_valid) return;
    if (scribble) begin
      ex_code[idx] = ~ex_code[idx];
      thr_id[idx]  = thr_id[idx] ^ 8'h5A;
    end
    for (int h = 0; h < hold; h++) begin
      if (early && h == 0) host_resume = 1'b1;
      step();
      host_resume = 1'b0;
    end
    exc_ready = 1'b1;
    step();
    exc_ready = 1'b0;
    if (late >= 0) begin
      ex_code[late]   = lcode;
      thr_id[late]    = lid;
      csr_stall[late] = 1'b1;
    end
    repeat ($urandom_range(0, 3)) step();
    host_resume = 1'b1;
    step();
    host_resume = 1'b0;
  endtask

  task automatic wait_idle(int last);
    int t = 0;
    while (busy && t < MAXW) begin
      step();
      t++;
    end
    chk("idle_timeout", 32'(busy), 0);
    chk("stall_clear_before_idle", 32'(csr_stall[last]), 0);
  endtask

  task automatic run_scenario(logic [N-1:0] mask, int late, int hold, bit early,
                              bit scribble, int force_code);
    logic [N-1:0] pend;
    logic [7:0]   lid;
    logic [5:0]   lcode;
    int           ptr;
    int           p;
    int           order[$];
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        ex_code[i] = (force_code >= 0) ? 6'(force_code) : rand_code();
        thr_id[i]  = 8'($urandom_range(0, 255));
      end
    end
    lid   = 8'($urandom_range(0, 255));
    lcode = rand_code();
    pend  = mask;
    ptr   = model_ptr;
    while (pend != '0) begin
      p = pick(pend, ptr);
      order.push_back(p);
      if (p == late) exp_q.push_back(pack_rep(p, lid, lcode));
      else           exp_q.push_back(pack_rep(p, thr_id[p], ex_code[p]));
      pend[p] = 1'b0;
      ptr = (p + 1) % N;
      if (order.size() == 1 && late >= 0) pend[late] = 1'b1;
    end
    model_ptr = ptr;
    csr_stall = csr_stall | mask;
    foreach (order[k]) begin
      serve_one(order[k], hold, early, scribble, (k == 0) ? late : -1, lid, lcode);
    end
    wait_idle(order[order.size() - 1]);
    chk("rr_ptr", 32'(dbg_rr_ptr), model_ptr);
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_clr_ex"}, 32'(clr_ex), 0);
    chk({tag, "_exc_valid"}, 32'(exc_valid), 0);
    chk({tag, "_exc_thr_id"}, 32'(exc_thr_id), 0);
    chk({tag, "_exc_code"}, 32'(exc_code), 0);
    chk({tag, "_exc_fatal"}, 32'(exc_fatal), 0);
    chk({tag, "_exc_count"}, 32'(exc_count), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_rr_ptr"}, 32'(dbg_rr_ptr), 0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // Reset lands in WAIT_RESUME; the still-pending stall must be re-reported.
  task automatic reset_scenario(int k);
    ex_code[k]   = rand_code();
    thr_id[k]    = 8'($urandom_range(0, 255));
    exp_q.push_back(pack_rep(k, thr_id[k], ex_code[k]));
    csr_stall[k] = 1'b1;
    wait_valid();
    exc_ready = 1'b1;
    step();
    exc_ready = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    step();
    chk("reset_no_clr", 32'(clr_ex), 0);
    step();
    chk("reset_no_clr2", 32'(clr_ex), 0);
    model_ptr = 0;
    exp_q.push_back(pack_rep(k, thr_id[k], ex_code[k]));
    rst_n = 1'b1;
    serve_one(k, 1, 1'b0, 1'b0, -1, 8'h00, 6'h00);
    wait_idle(k);
    model_ptr = (k + 1) % N;
    chk("rr_ptr_after_reset", 32'(dbg_rr_ptr), model_ptr);
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    csr_stall   = '0;
    ex_code     = '0;
    thr_id      = '0;
    exc_ready   = 1'b0;
    host_resume = 1'b0;
    rst_n       = 1'b0;
    for (int i = 0; i < N; i++) drop_cd[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    step();

    // Thread 2 segfault with host always ready.
    ex_code[2]   = 6'h12;
    thr_id[2]    = 8'hC2;
    exp_q.push_back(pack_rep(2, 8'hC2, 6'h12));
    exc_ready    = 1'b1;
    csr_stall[2] = 1'b1;
    step();
    chk("latency_valid", 32'(exc_valid), 1);
    serve_one(2, 0, 1'b0, 1'b1, -1, 8'h00, 6'h00);
    wait_idle(2);
    model_ptr = 3;
    chk("rr_ptr_after_t2", 32'(dbg_rr_ptr), 3);

    // Fresh reset, then threads 0, 1, 3 together from rr_ptr 0.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    model_ptr = 0;
    step();
    run_scenario(4'b1011, -1, 1, 1'b0, 1'b1, -1);

    // Host stalls ready for 5 cycles.
    run_scenario(4'b0010, -1, 5, 1'b0, 1'b1, -1);

    // Breakpoint with an early host_resume during REPORT.
    run_scenario(4'b0100, -1, 3, 1'b1, 1'b1, 6'h3F);

    // Late stall arriving while busy.
    run_scenario(4'b0001, 2, 1, 1'b0, 1'b1, -1);

    reset_scenario(1);

    for (int s = 0; s < 36; s++) begin
      logic [N-1:0] m;
      int late;
      int cand;
      m = N'($urandom_range(1, (1 << N) - 1));
      late = -1;
      if (m != '1 && $urandom_range(0, 1) == 1) begin
        do cand = $urandom_range(0, N - 1); while (m[cand]);
        late = cand;
      end
      run_scenario(m, late, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b1, -1);
    end

    repeat (4) step();
    chk("exp_q_empty", 32'(exp_q.size()), 0);
    chk("final_busy", 32'(busy), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
